// File: rtl/memory_stage_pkg.sv
// Shared Y86-64 definitions for the memory stage: icodes, register "none", W-register layout.
// Also provides the icode-to-memory-operation decode used by the stage.
package memory_stage_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE     = 4'hF;
  localparam logic [3:0] NOP_ICODE = I_NOP;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WR   = 2'd2
  } mem_op_e;

  typedef struct packed {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        hlt;
    logic        in_inst;
    logic        in_mem;
  } wreg_t;

  function automatic mem_op_e decode_mem_op(input logic [3:0] icode);
    case (icode)
      I_MRMOVQ, I_POPQ, I_RET:  decode_mem_op = MEM_RD;
      I_RMMOVQ, I_PUSHQ, I_CALL: decode_mem_op = MEM_WR;
      default:                   decode_mem_op = MEM_NONE;
    endcase
  endfunction

  function automatic wreg_t bubble_w();
    bubble_w         = '0;
    bubble_w.icode   = NOP_ICODE;
    bubble_w.dstE    = RNONE;
    bubble_w.dstM    = RNONE;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// M-register inputs, W-register controls and the stage outputs of the memory stage.
// master drives the M side (execute/control), slave is the memory stage itself.
interface memory_stage_if;
  logic [3:0]  M_icode;
  logic        M_cond;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        M_hlt;
  logic        M_in_inst;
  logic        M_in_mem;
  logic        W_stall;
  logic        W_bubble;

  logic [63:0] m_valM;
  logic        m_hlt;
  logic        m_in_inst;
  logic        m_in_mem;

  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic        W_hlt;
  logic        W_in_inst;
  logic        W_in_mem;

  modport master (
    output M_icode, M_cond, M_valE, M_valA, M_dstE, M_dstM,
           M_hlt, M_in_inst, M_in_mem, W_stall, W_bubble,
    input  m_valM, m_hlt, m_in_inst, m_in_mem,
           W_icode, W_valE, W_valM, W_dstE, W_dstM, W_hlt, W_in_inst, W_in_mem
  );

  modport slave (
    input  M_icode, M_cond, M_valE, M_valA, M_dstE, M_dstM,
           M_hlt, M_in_inst, M_in_mem, W_stall, W_bubble,
    output m_valM, m_hlt, m_in_inst, m_in_mem,
           W_icode, W_valE, W_valM, W_dstE, W_dstM, W_hlt, W_in_inst, W_in_mem
  );
endinterface

// File: rtl/memory_stage_dmem_ram.sv
// Byte-addressed little-endian data memory: one combinational 8-byte read port,
// one synchronous 8-byte write port. Addresses wrap within the array; contents are never reset.
module dmem_ram #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(DMEM_BYTES)-1:0] waddr,
  input  logic [63:0]                   wdata,
  input  logic [$clog2(DMEM_BYTES)-1:0] raddr,
  output logic [63:0]                   rdata
);
  localparam int AW = $clog2(DMEM_BYTES);

  logic [7:0] r_mem [DMEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[waddr + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = r_mem[raddr + AW'(k)];
    end
  end
endmodule

// File: rtl/memory_stage.sv
// Y86-64 PIPE memory stage: address select, data-memory access, status merge and W register.
// Optional macro MEM_ALIGN_CHK_EN: treat any active access with addr[2:0] != 0 as an address error.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DMEM_BYTES = 1024
) (
  input logic           clk,
  input logic           rst,
  memory_stage_if.slave bus
);
  localparam int AW = $clog2(DMEM_BYTES);

  mem_op_e     w_op;
  logic [63:0] w_addr;
  logic        w_range_err;
  logic        w_align_err;
  logic        w_dmem_err;
  logic        w_we;
  logic [63:0] w_rdata;
  wreg_t       r_w;

  assign w_op   = decode_mem_op(bus.M_icode);
  // Stack pops read through the old stack pointer carried in valA.
  assign w_addr = (bus.M_icode == I_POPQ || bus.M_icode == I_RET) ? bus.M_valA : bus.M_valE;

  assign w_range_err = (w_addr > 64'(DMEM_BYTES - 8));
`ifdef MEM_ALIGN_CHK_EN
  assign w_align_err = (w_addr[2:0] != 3'd0);
`else
  assign w_align_err = 1'b0;
`endif
  assign w_dmem_err = (w_op != MEM_NONE) && (w_range_err || w_align_err);

  // Any faulting instruction in M must leave memory untouched.
  assign w_we = (w_op == MEM_WR) && !w_dmem_err && !bus.M_hlt && !bus.M_in_inst
                && !bus.M_in_mem && !rst;

  dmem_ram #(.DMEM_BYTES(DMEM_BYTES)) u_dmem (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_addr[AW-1:0]),
    .wdata (bus.M_valA),
    .raddr (w_addr[AW-1:0]),
    .rdata (w_rdata)
  );

  assign bus.m_valM    = (w_op == MEM_RD && !w_dmem_err) ? w_rdata : 64'd0;
  assign bus.m_hlt     = bus.M_hlt;
  assign bus.m_in_inst = bus.M_in_inst;
  assign bus.m_in_mem  = bus.M_in_mem | w_dmem_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w <= bubble_w();
    end else if (bus.W_stall) begin
      r_w <= r_w;
    end else if (bus.W_bubble) begin
      r_w <= bubble_w();
    end else begin
      r_w.icode   <= bus.M_icode;
      r_w.valE    <= bus.M_valE;
      r_w.valM    <= bus.m_valM;
      r_w.dstE    <= bus.M_dstE;
      r_w.dstM    <= bus.M_dstM;
      r_w.hlt     <= bus.m_hlt;
      r_w.in_inst <= bus.m_in_inst;
      r_w.in_mem  <= bus.m_in_mem;
    end
  end

  assign bus.W_icode   = r_w.icode;
  assign bus.W_valE    = r_w.valE;
  assign bus.W_valM    = r_w.valM;
  assign bus.W_dstE    = r_w.dstE;
  assign bus.W_dstM    = r_w.dstM;
  assign bus.W_hlt     = r_w.hlt;
  assign bus.W_in_inst = r_w.in_inst;
  assign bus.W_in_mem  = r_w.in_mem;
endmodule
